// File: rtl/instr_encoder.sv
// RV32I instruction word assembler and sequential IMEM program loader.
// Scatters a 32-bit immediate into per-format bit positions (inverse of the immediate extender).
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024,
  localparam int                   CW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [2:0]            in_funct3,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [CW-1:0]         count
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // LOAD  | accepting requests, writing encoded words
  // DONE  | session ended normally (in_last or MAX_WORDS reached)
  // ERROR | session aborted on a bad request, err_code holds the cause
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2,
                         FMT_J = 3'd3, FMT_U = 3'd4, FMT_R = 3'd5;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           enc;
  logic [1:0]            code;
  logic                  xfer, last_word;
  logic                  fits12, fits13, fits21;

  assign xfer      = in_valid && (state == LOAD);
  assign last_word = in_last || (count == CW'(MAX_WORDS - 1));

  // Sign-extension checks: every bit above the field's sign bit must match it.
  assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
  assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

  always_comb begin
    enc  = '0;
    code = 2'b00;
    case (in_fmt)
      FMT_I: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!fits12) code = 2'b01;
      end
      FMT_S: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!fits12) code = 2'b01;
      end
      FMT_B: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0])    code = 2'b10;
        else if (!fits13) code = 2'b01;
      end
      FMT_J: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])    code = 2'b10;
        else if (!fits21) code = 2'b01;
      end
      FMT_U: begin
        enc = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != 12'd0) code = 2'b10;
      end
      FMT_R: begin
        enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: code = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = LOAD;
      LOAD: begin
        if (xfer) begin
          if (code != 2'b00) state_nxt = ERROR;
          else if (last_word) state_nxt = DONE;
        end
      end
      DONE, ERROR: if (start) state_nxt = LOAD;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state == LOAD);
    done     = (state == DONE);
    err      = (state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      next_addr  <= '0;
      count      <= '0;
      err_code   <= 2'b00;
    end else begin
      imem_we <= 1'b0;
      if (state != LOAD && start) begin
        next_addr <= BASE_ADDR;
        count     <= '0;
        err_code  <= 2'b00;
      end else if (xfer) begin
        if (code != 2'b00) begin
          err_code <= code;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= next_addr;
          imem_wdata <= enc;
          next_addr  <= next_addr + ADDR_WIDTH'(4);
          count      <= count + CW'(1);
        end
      end
    end
  end

endmodule
